ap3216_i2c_responder: RTL

- Synthesizable I2C target (responder) that emulates the AP3216 ambient-light/proximity sensor.
- Answers the design's I2C initiator (the sensor-polling master) for loopback bring-up, so the initiator can be exercised on boards without the sensor fitted.
- Oversamples SCL/SDA on the 50 MHz system clock, decodes the bus, and serves a 16-byte register map.
- Registers 0x0A–0x0F (IR/ALS/PS data) are fed from live inputs.

---
 rtl/ap3216_i2c_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ap3216_i2c_responder.sv
// ap3216_i2c_responder
//   I2C target that stands in for an AP3216 ambient-light/proximity sensor so
//   the sensor-polling initiator can be brought up on boards without the part.
//   SCL/SDA are oversampled on the 50 MHz system clock (2-flop synchronizer,
//   FILT_LEN-sample glitch filter, edge detect). The target serves a 16-byte
//   register map: 0x00-0x09 are writable storage, and 0x0A-0x0F mirror the live
//   IR/ALS/PS inputs through a shadow captured at the start of each read.
//   Pointers 0x10-0xFF read as 0x00, and writes to them are discarded.
//
// Ports
//   I_clk        system clock, 50 MHz
//   I_rst        asynchronous active-high reset
//   I_scl        bus SCL, raw
//   I_sda        bus SDA, raw pad input
//   O_sda_oe     1 = pull SDA low, 0 = release (open-drain)
//   I_als_data   ALS value (regs 0x0C low byte, 0x0D high byte)
//   I_ps_data    PS value (reg 0x0E = [3:0], reg 0x0F = [9:4])
//   I_ir_data    IR value (reg 0x0A = [1:0], reg 0x0B = [9:2])
//   O_sys_cfg    current contents of register 0x00
//   O_wr_stb     one-cycle pulse per accepted register write
//   O_wr_addr    register pointer of that write
//   O_wr_data    data byte of that write
//   O_busy       high while this device is addressed, until STOP
//   O_dbg_state  current FSM state (debug observation)
//
// Write notification: O_wr_stb is a valid-only strobe with no ready. O_wr_addr
// and O_wr_data are valid in the same cycle that O_wr_stb is high, and they hold
// until the next strobe. The consumer cannot stall it and must take it that cycle.

module ap3216_i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1E,
    parameter int         FILT_LEN = 3
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_scl,
    input  logic        I_sda,
    output logic        O_sda_oe,
    input  logic [15:0] I_als_data,
    input  logic [9:0]  I_ps_data,
    input  logic [9:0]  I_ir_data,
    output logic [7:0]  O_sys_cfg,
    output logic        O_wr_stb,
    output logic [7:0]  O_wr_addr,
    output logic [7:0]  O_wr_data,
    output logic        O_busy,
    output logic [3:0]  O_dbg_state
);

    // FSM encoding
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WR_DATA   = 4'd5;
    localparam logic [3:0] ST_WR_ACK    = 4'd6;
    localparam logic [3:0] ST_RD_DATA   = 4'd7;
    localparam logic [3:0] ST_RD_ACK    = 4'd8;
    localparam logic [3:0] ST_WAIT_STOP = 4'd9;
    localparam logic [3:0] ST_IGNORE    = 4'd10;

    // First pointer value outside the writable register bank.
    localparam logic [7:0] RW_TOP = 8'h0A;

    localparam int             CW      = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_LEN - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]    scl_sync;
    logic [1:0]    sda_sync;
    logic          scl_filt;
    logic          sda_filt;
    logic [CW-1:0] scl_cnt;
    logic [CW-1:0] sda_cnt;
    logic          scl_filt_d;
    logic          sda_filt_d;

    // The synchronizers preset to 1 so that reset does not look like a bus event.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], I_scl};
            sda_sync <= {sda_sync[0], I_sda};
        end
    end

    // The glitch filter counts consecutive samples that differ from the
    // accepted level. The new level is taken on the FILT_LEN-th such sample.
    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            scl_filt <= 1'b1;
            scl_cnt  <= '0;
        end else if (scl_sync[1] == scl_filt) begin
            scl_cnt  <= '0;
        end else if (scl_cnt == CNT_MAX) begin
            scl_filt <= scl_sync[1];
            scl_cnt  <= '0;
        end else begin
            scl_cnt  <= scl_cnt + 1'b1;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            sda_filt <= 1'b1;
            sda_cnt  <= '0;
        end else if (sda_sync[1] == sda_filt) begin
            sda_cnt  <= '0;
        end else if (sda_cnt == CNT_MAX) begin
            sda_filt <= sda_sync[1];
            sda_cnt  <= '0;
        end else begin
            sda_cnt  <= sda_cnt + 1'b1;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            scl_filt_d <= 1'b1;
            sda_filt_d <= 1'b1;
        end else begin
            scl_filt_d <= scl_filt;
            sda_filt_d <= sda_filt;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  = scl_filt & ~scl_filt_d;
    assign scl_fall  = ~scl_filt & scl_filt_d;
    // SCL must be high both before and after the SDA edge. This rejects an
    // SDA change that lands in the same cycle as an SCL edge.
    assign start_det = scl_filt & scl_filt_d & sda_filt_d & ~sda_filt;
    assign stop_det  = scl_filt & scl_filt_d & ~sda_filt_d & sda_filt;

    // ------------------------------------------------------------------
    // Register map and read mux
    // ------------------------------------------------------------------
    logic [3:0]  state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  rd_shift;
    logic [7:0]  ptr;
    logic        rw;
    logic        rd_ack_ok;
    logic [7:0]  regs [0:9];
    logic [15:0] sh_als;
    logic [9:0]  sh_ps;
    logic [9:0]  sh_ir;
    logic [7:0]  rd_byte;
    logic [7:0]  shift_in;

    assign shift_in    = {shift[6:0], sda_filt};
    assign O_sys_cfg   = regs[0];
    assign O_dbg_state = state;

    // Data registers are served from the shadow. Every byte of one read burst
    // then comes from a single capture of the live inputs.
    always_comb begin
        rd_byte = 8'h00;
        if (ptr < RW_TOP) begin
            rd_byte = regs[ptr[3:0]];
        end else begin
            case (ptr)
                8'h0A:   rd_byte = {6'b0, sh_ir[1:0]};
                8'h0B:   rd_byte = sh_ir[9:2];
                8'h0C:   rd_byte = sh_als[7:0];
                8'h0D:   rd_byte = sh_als[15:8];
                8'h0E:   rd_byte = {4'b0, sh_ps[3:0]};
                8'h0F:   rd_byte = {2'b0, sh_ps[9:4]};
                default: rd_byte = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Protocol FSM
    //   Incoming bits are shifted on SCL rise. Each byte boundary is acted on
    //   at the SCL fall that follows the 8th rise. O_sda_oe only moves in the
    //   cycle after a detected SCL fall, so SDA is never changed while SCL is
    //   high. START and STOP override every state.
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            rd_shift  <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            rd_ack_ok <= 1'b0;
            O_sda_oe  <= 1'b0;
            O_busy    <= 1'b0;
            O_wr_stb  <= 1'b0;
            O_wr_addr <= '0;
            O_wr_data <= '0;
            sh_als    <= '0;
            sh_ps     <= '0;
            sh_ir     <= '0;
            for (int i = 0; i < 10; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            O_wr_stb <= 1'b0;
            if (start_det) begin
                // A repeated START keeps ptr, so a pointer write can be
                // followed directly by a read.
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                O_sda_oe <= 1'b0;
            end else if (stop_det) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                O_sda_oe <= 1'b0;
                O_busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shift[7:1] == DEV_ADDR) begin
                                state    <= ST_ADDR_ACK;
                                O_sda_oe <= 1'b1;
                                O_busy   <= 1'b1;
                                rw       <= shift[0];
                                // Capture here so the shadow is settled before
                                // the first data bit is driven.
                                if (shift[0]) begin
                                    sh_als <= I_als_data;
                                    sh_ps  <= I_ps_data;
                                    sh_ir  <= I_ir_data;
                                end
                            end else begin
                                state  <= ST_IGNORE;
                                O_busy <= 1'b0;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                state    <= ST_RD_DATA;
                                O_sda_oe <= ~rd_byte[7];
                                rd_shift <= {rd_byte[6:0], 1'b0};
                                bit_cnt  <= 4'd1;
                            end else begin
                                state    <= ST_REG;
                                O_sda_oe <= 1'b0;
                                bit_cnt  <= '0;
                            end
                        end
                    end

                    ST_REG: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr      <= shift;
                            O_sda_oe <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= ST_REG_ACK;
                        end
                    end

                    ST_REG_ACK: begin
                        if (scl_fall) begin
                            O_sda_oe <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= ST_WR_DATA;
                        end
                    end

                    ST_WR_DATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            O_sda_oe <= 1'b1;
                            bit_cnt  <= '0;
                            state    <= ST_WR_ACK;
                            // Bytes outside the writable bank are still ACKed,
                            // but they are dropped and produce no strobe.
                            if (ptr < RW_TOP) begin
                                regs[ptr[3:0]] <= shift;
                                O_wr_stb       <= 1'b1;
                                O_wr_addr      <= ptr;
                                O_wr_data      <= shift;
                            end
                        end
                    end

                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            O_sda_oe <= 1'b0;
                            ptr      <= ptr + 8'd1;
                            bit_cnt  <= '0;
                            state    <= ST_WR_DATA;
                        end
                    end

                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                O_sda_oe  <= 1'b0;
                                rd_ack_ok <= 1'b0;
                                state     <= ST_RD_ACK;
                            end else begin
                                O_sda_oe <= ~rd_shift[7];
                                rd_shift <= {rd_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        // ptr advances on the ACK rise, so rd_byte already
                        // shows the next register when the ACK clock falls.
                        if (scl_rise) begin
                            if (!sda_filt) begin
                                rd_ack_ok <= 1'b1;
                                ptr       <= ptr + 8'd1;
                            end else begin
                                state <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall && rd_ack_ok) begin
                            state    <= ST_RD_DATA;
                            O_sda_oe <= ~rd_byte[7];
                            rd_shift <= {rd_byte[6:0], 1'b0};
                            bit_cnt  <= 4'd1;
                        end
                    end

                    // IDLE, WAIT_STOP and IGNORE only leave on START/STOP.
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
